// File: rtl/synth_sysex_pkg.sv
// Shared SysEx framing constants, dump FSM state encoding and checksum helper.
package synth_sysex_pkg;

  localparam logic [7:0] SX_SOX = 8'hF0;
  localparam logic [7:0] SX_EOX = 8'hF7;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    SETUP,
    RD,
    SEND_HI,
    SEND_LO,
    NEXT,
    CKSUM,
    EOX,
    DONE
  } sx_state_t;

  // Two's complement of the 7-bit running sum, so that sum + ck wraps to zero.
  function automatic logic [7:0] sx_cksum7(input logic [6:0] sum);
    logic [6:0] neg;
    neg = 7'd0 - sum;
    return {1'b0, neg};
  endfunction

endpackage

// File: rtl/patch_bus_reader.sv
// Single-register read cycle on the patch-parameter bus: latch bank/adr on go,
// hold them SETUP_CYC clocks, pulse read for READ_CYC clocks, capture data_in.
module patch_bus_reader
  import synth_sysex_pkg::*;
#(
  parameter int BANKS     = 4,
  parameter int SETUP_CYC = 2,
  parameter int READ_CYC  = 2,
  parameter int BW        = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic             OSC_CLK,
  input  logic             iRST,
  input  logic             go,
  input  logic             clr,
  input  logic [BW-1:0]    bank,
  input  logic [6:0]       adr,
  input  logic [7:0]       data_in,
  output logic             rdy,
  output logic             read,
  output logic [BANKS-1:0] bank_sel,
  output logic [6:0]       bus_adr,
  output logic [7:0]       d
);

  typedef enum logic [1:0] {P_IDLE, P_SETUP, P_READ} phase_t;

  phase_t     ph;
  logic [7:0] cnt;
  logic       setup_last;

  assign setup_last = (cnt + 8'd1) == 8'(SETUP_CYC);
  // rdy marks the last read-high clock; data is captured on the edge that ends it.
  assign rdy        = (ph == P_READ) && ((cnt + 8'd1) == 8'(READ_CYC));

  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      ph       <= P_IDLE;
      cnt      <= '0;
      read     <= 1'b0;
      bank_sel <= '0;
      bus_adr  <= '0;
      d        <= '0;
    end else begin
      if (clr) begin
        bank_sel <= '0;
        bus_adr  <= '0;
      end else if (go) begin
        bank_sel <= BANKS'(1) << bank;
        bus_adr  <= adr;
      end

      case (ph)
        P_IDLE: begin
          if (go) begin
            ph  <= P_SETUP;
            cnt <= '0;
          end
        end
        P_SETUP: begin
          if (setup_last) begin
            ph   <= P_READ;
            read <= 1'b1;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        P_READ: begin
          if (rdy) begin
            ph   <= P_IDLE;
            read <= 1'b0;
            d    <= data_in;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ph <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/patch_dump_tx.sv
// Walks every bank/address of the patch bus and streams one SysEx frame per bank
// to the UART over valid/ready, at most one byte per two clocks.
module patch_dump_tx
  import synth_sysex_pkg::*;
#(
  parameter int         BANKS     = 4,
  parameter int         NUM_ADR   = 128,
  parameter logic [7:0] MANUF_ID  = 8'h7D,
  parameter logic [7:0] DEV_ID    = 8'h00,
  parameter int         SETUP_CYC = 2,
  parameter int         READ_CYC  = 2
) (
  input  logic             OSC_CLK,
  input  logic             iRST,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [BANKS-1:0] bank_sel,
  output logic [6:0]       adr,
  output logic             read,
  output logic             sysex_data_patch_send,
  input  logic [7:0]       data_in,
  output logic [7:0]       tx_byte,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int            BW        = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [7:0]    ADR_LAST  = 8'(NUM_ADR - 1);
  localparam logic [BW-1:0] BANK_LAST = BW'(BANKS - 1);

  sx_state_t     state;
  logic [BW-1:0] bank;
  logic [7:0]    adr_q;
  logic [1:0]    hcnt;
  logic [6:0]    sum;
  logic [7:0]    d;
  logic [7:0]    cur_byte;
  logic [7:0]    rd_adr;
  logic          in_send, xfer, last_adr, go, clr, rdy;

  always_comb begin
    cur_byte = 8'h00;
    in_send  = 1'b1;
    case (state)
      HDR: begin
        case (hcnt)
          2'd0:    cur_byte = SX_SOX;
          2'd1:    cur_byte = MANUF_ID;
          2'd2:    cur_byte = DEV_ID;
          default: cur_byte = {1'b0, 7'(bank)};
        endcase
      end
      SEND_HI: cur_byte = {7'b0, d[7]};
      SEND_LO: cur_byte = {1'b0, d[6:0]};
      CKSUM:   cur_byte = sx_cksum7(sum);
      EOX:     cur_byte = SX_EOX;
      default: in_send  = 1'b0;
    endcase
  end

  assign xfer     = tx_valid && tx_ready;
  assign last_adr = (adr_q == ADR_LAST);
  // go/clr are combinational so the reader's bus registers move on the same
  // edge the FSM enters SETUP or leaves the bank.
  assign go       = ((state == HDR) && xfer && (hcnt == 2'd3)) || ((state == NEXT) && !last_adr);
  assign clr      = (state == EOX) && xfer;
  assign rd_adr   = (state == NEXT) ? adr_q + 8'd1 : adr_q;

  patch_bus_reader #(
    .BANKS     (BANKS),
    .SETUP_CYC (SETUP_CYC),
    .READ_CYC  (READ_CYC),
    .BW        (BW)
  ) u_reader (
    .OSC_CLK  (OSC_CLK),
    .iRST     (iRST),
    .go       (go),
    .clr      (clr),
    .bank     (bank),
    .adr      (rd_adr[6:0]),
    .data_in  (data_in),
    .rdy      (rdy),
    .read     (read),
    .bank_sel (bank_sel),
    .bus_adr  (adr),
    .d        (d)
  );

  always_ff @(posedge OSC_CLK) begin
    if (iRST) begin
      state                 <= IDLE;
      bank                  <= '0;
      adr_q                 <= '0;
      hcnt                  <= '0;
      sum                   <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      sysex_data_patch_send <= 1'b0;
      tx_byte               <= '0;
      tx_valid              <= 1'b0;
    end else begin
      done <= 1'b0;

      // Valid drops after every transfer, forcing an idle clock between bytes.
      if (in_send) begin
        if (!tx_valid) begin
          tx_valid <= 1'b1;
          tx_byte  <= cur_byte;
        end else if (tx_ready) begin
          tx_valid <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state                 <= HDR;
            busy                  <= 1'b1;
            sysex_data_patch_send <= 1'b1;
            bank                  <= '0;
            adr_q                 <= '0;
            hcnt                  <= '0;
          end
        end
        HDR: begin
          if (xfer) begin
            if (hcnt == 2'd0) sum <= '0;
            if (hcnt == 2'd3) begin
              sum   <= sum + tx_byte[6:0];
              state <= SETUP;
            end else begin
              hcnt <= hcnt + 2'd1;
            end
          end
        end
        SETUP:   if (read) state <= RD;
        RD:      if (rdy) state <= SEND_HI;
        SEND_HI: begin
          if (xfer) begin
            sum   <= sum + tx_byte[6:0];
            state <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (xfer) begin
            sum   <= sum + tx_byte[6:0];
            state <= NEXT;
          end
        end
        NEXT: begin
          if (last_adr) begin
            state <= CKSUM;
          end else begin
            adr_q <= rd_adr;
            state <= SETUP;
          end
        end
        CKSUM: if (xfer) state <= EOX;
        EOX: begin
          if (xfer) begin
            adr_q <= '0;
            hcnt  <= '0;
            if (bank == BANK_LAST) begin
              state                 <= DONE;
              done                  <= 1'b1;
              busy                  <= 1'b0;
              sysex_data_patch_send <= 1'b0;
            end else begin
              bank  <= bank + BW'(1);
              state <= HDR;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_patch_dump_tx.sv
// Scoreboard bench: expected SysEx bytes are queued at start, a negedge monitor
// pops on every transfer and also polices the bus read timing.
module tb_patch_dump_tx;

  localparam int BANKS     = 4;
  localparam int NUM_ADR   = 8;
  localparam int SETUP_CYC = 2;
  localparam int READ_CYC  = 2;
  localparam int FRAME     = 4 + 2 * NUM_ADR + 2;

  logic             OSC_CLK = 1'b0;
  logic             iRST = 1'b1;
  logic             start = 1'b0;
  logic             tx_ready = 1'b1;
  logic             busy, done, read, sysex_data_patch_send, tx_valid;
  logic [BANKS-1:0] bank_sel;
  logic [6:0]       adr;
  logic [7:0]       data_in, tx_byte;

  int         tests = 0;
  int         fails = 0;
  int         n_xfer = 0;
  int         n_done = 0;
  int         rd_idx = 0;
  int         stable = 0;
  logic [7:0] exp_q[$];

  always #5 OSC_CLK = ~OSC_CLK;

  patch_dump_tx #(
    .BANKS     (BANKS),
    .NUM_ADR   (NUM_ADR),
    .MANUF_ID  (8'h7D),
    .DEV_ID    (8'h00),
    .SETUP_CYC (SETUP_CYC),
    .READ_CYC  (READ_CYC)
  ) dut (
    .OSC_CLK               (OSC_CLK),
    .iRST                  (iRST),
    .start                 (start),
    .busy                  (busy),
    .done                  (done),
    .bank_sel              (bank_sel),
    .adr                   (adr),
    .read                  (read),
    .sysex_data_patch_send (sysex_data_patch_send),
    .data_in               (data_in),
    .tx_byte               (tx_byte),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready)
  );

  function automatic logic [7:0] bus_data(input int b, input int a);
    if (b == 0) return (a == 6) ? 8'h85 : 8'h00;
    return 8'(b * 53 + a * 29 + (a << 6));
  endfunction

  // Bank model: the selected bank drives its register while the enable is high.
  always_comb begin
    data_in = 8'h00;
    for (int i = 0; i < BANKS; i++)
      if (sysex_data_patch_send && bank_sel[i]) data_in = bus_data(i, int'(adr));
  end

  task automatic push_dump();
    logic [7:0] b0 [FRAME] = '{8'hF0, 8'h7D, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h01, 8'h05, 8'h00, 8'h00, 8'h7A, 8'hF7};
    for (int i = 0; i < FRAME; i++) exp_q.push_back(b0[i]);
    for (int b = 1; b < BANKS; b++) begin
      int s;
      logic [7:0] dv;
      exp_q.push_back(8'hF0);
      exp_q.push_back(8'h7D);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'(b));
      s = b;
      for (int a = 0; a < NUM_ADR; a++) begin
        dv = bus_data(b, a);
        exp_q.push_back({7'b0, dv[7]});
        exp_q.push_back({1'b0, dv[6:0]});
        s = (s + int'(dv[7]) + int'(dv[6:0])) % 128;
      end
      exp_q.push_back(8'((128 - s) % 128));
      exp_q.push_back(8'hF7);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic pulse_start();
    @(posedge OSC_CLK); #2 start = 1'b1;
    @(posedge OSC_CLK); #2 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (n_done == 0 && c < 5000) begin
      @(posedge OSC_CLK);
      c++;
    end
    if (n_done == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout done got 0 expected 1", tag);
    end
    repeat (3) @(posedge OSC_CLK);
    #2;
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_bytes"}, n_xfer, BANKS * FRAME);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_read_pulses"}, rd_idx, BANKS * NUM_ADR);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({busy, done, bank_sel, adr, read, sysex_data_patch_send, tx_valid, tx_byte});
  endfunction

  // Monitor: scoreboard pops, done/enable checks, read setup/hold checks.
  logic             prev_read = 1'b0;
  logic [BANKS-1:0] prev_bs = '0;
  logic [6:0]       prev_adr = '0;
  always @(negedge OSC_CLK) begin
    logic [7:0]       e;
    logic [BANKS-1:0] exp_bs;
    logic             changed;
    if (iRST) begin
      rd_idx = 0;
      stable = 0;
    end else begin
      if (start && !busy) begin
        n_xfer = 0;
        n_done = 0;
        rd_idx = 0;
      end
      if (tx_valid && tx_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL tx_extra byte %0d got %02h expected none", n_xfer, tx_byte);
        end else begin
          e = exp_q.pop_front();
          if (tx_byte !== e) begin
            fails++;
            $display("FAIL tx_byte[%0d] got %02h expected %02h", n_xfer, tx_byte, e);
          end
        end
        n_xfer++;
      end
      if (done) begin
        n_done++;
        tests++;
        if (busy || bank_sel != '0 || adr != 7'd0 || sysex_data_patch_send) begin
          fails++;
          $display("FAIL done_state busy=%b bank_sel=%b adr=%0d send=%b expected all 0",
                   busy, bank_sel, adr, sysex_data_patch_send);
        end
      end
      if (busy) begin
        tests++;
        if (!sysex_data_patch_send) begin
          fails++;
          $display("FAIL send_enable got 0 expected 1 while busy");
        end
      end
      changed = (adr != prev_adr) || (bank_sel != prev_bs);
      if (read && !prev_read) begin
        exp_bs = BANKS'(1) << (rd_idx / NUM_ADR);
        tests++;
        if (stable < SETUP_CYC || bank_sel != exp_bs || adr != 7'(rd_idx % NUM_ADR)) begin
          fails++;
          $display("FAIL rd_setup[%0d] stable=%0d bank_sel=%b adr=%0d expected stable>=%0d bank_sel=%b adr=%0d",
                   rd_idx, stable, bank_sel, adr, SETUP_CYC, exp_bs, rd_idx % NUM_ADR);
        end
        rd_idx++;
      end
      if (read && prev_read && changed) begin
        tests++;
        fails++;
        $display("FAIL rd_hold adr=%0d bank_sel=%b changed expected %0d %b",
                 adr, bank_sel, prev_adr, prev_bs);
      end
      stable = changed ? 1 : stable + 1;
    end
    prev_read = read;
    prev_bs   = bank_sel;
    prev_adr  = adr;
  end

  initial begin
    logic [7:0] held;
    int c;

    repeat (3) @(posedge OSC_CLK);
    #2 chk("reset_outputs", all_outs(), 32'h0);
    iRST = 1'b0;

    // Dump 1: stall on byte 5, stray start pulses while busy.
    push_dump();
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'h1);
    c = 0;
    while (n_xfer < 4 && c < 2000) begin
      @(posedge OSC_CLK); #2;
      c++;
    end
    chk("reach_byte5", 32'(n_xfer >= 4), 32'h1);
    tx_ready = 1'b0;
    c = 0;
    while (!tx_valid && c < 200) begin
      @(posedge OSC_CLK); #2;
      c++;
    end
    chk("stall_valid_rise", 32'(tx_valid), 32'h1);
    held = tx_byte;
    for (int i = 0; i < 10; i++) begin
      @(posedge OSC_CLK); #2;
      chk("stall_hold", {23'b0, tx_valid, tx_byte}, {23'b0, 1'b1, held});
    end
    tx_ready = 1'b1;
    repeat (40) @(posedge OSC_CLK);
    pulse_start();
    repeat (100) @(posedge OSC_CLK);
    pulse_start();
    wait_done("dump1");
    end_checks("dump1");
    chk("idle_after_done", all_outs() & 32'hFFFF00, 32'h0);

    // Dump 2: reset in the middle of the payload.
    push_dump();
    pulse_start();
    c = 0;
    while (n_xfer < 10 && c < 2000) begin
      @(posedge OSC_CLK); #2;
      c++;
    end
    iRST = 1'b1;
    @(posedge OSC_CLK); #2;
    chk("midreset_outputs", all_outs(), 32'h0);
    iRST = 1'b0;
    exp_q.delete();

    // Dump 3: full dump after the abort must start cleanly with F0.
    push_dump();
    pulse_start();
    wait_done("dump3");
    end_checks("dump3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
